tetris_move_scheduler: RTL and testbench
========================================

Name: tetris_move_scheduler

Overview:
Sequences all piece-movement commands into the Tetris game FSM. It edge-detects the four player buttons and generates gravity drop ticks from an internal counter. Pending requests are arbitrated by fixed priority and issued one at a time as move_t codes over a valid/ready handshake. It sits between the button synchronizers/debouncers and the game FSM's move input.

Parameters:
DROP_PERIOD, 100, clock cycles between gravity DOWN ticks at normal speed (>=2)
FAST_PERIOD, 10, clock cycles between gravity ticks while soft-drop held (>=2, < DROP_PERIOD)
CW, 16, gravity counter width; must hold DROP_PERIOD-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  game active (game FSM in a playable state); 0 = scheduler idle
right  in  1  synchronized level, move right button
left  in  1  synchronized level, move left button
rr  in  1  synchronized level, rotate right button
rl  in  1  synchronized level, rotate left button
soft_drop  in  1  level; selects FAST_PERIOD while high
cmd_ready_i  in  1  game FSM accepts a command this cycle
cmd_valid_o  out  1  command available
cmd_o  out  3  move_t code: RIGHT=0, LEFT=1, ROR=2, ROL=3, DOWN=4
busy_o  out  1  any request pending or command in flight
missed_tick_o  out  1  sticky: a gravity tick arrived while DOWN was already pending

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high. On reset all registers clear: cmd_valid_o=0, cmd_o=0 (RIGHT), busy_o=0, missed_tick_o=0, pending bits=0, gravity counter=0, button history=0, state=IDLE.
- Edge detect: register the previous level of each button. A rising edge (cur=1, prev=0) sets that button's pending bit at the next clk edge. Holding a button produces one request only.
- Cancellation: right and left rising in the same cycle sets neither bit. rr and rl rising in the same cycle sets neither bit.
- Gravity: the counter increments each cycle while en=1. Terminal value is DROP_PERIOD-1, or FAST_PERIOD-1 when soft_drop=1. If the counter is already >= the terminal value (for example when soft_drop has just been raised), treat it as terminal.
- At terminal, the counter wraps to 0 and sets pend_down. If pend_down is already set and is not being cleared this cycle, the tick is dropped and missed_tick_o is set to 1. missed_tick_o clears only on rst.
- The counter runs in all states while en=1.
- FSM states IDLE, ARB, ISSUE:
  - IDLE: entered whenever en=0, from any state. Pending bits, counter and button history clear; cmd_valid_o=0. Go to ARB when en=1.
  - ARB: if any pending bit is set, latch cmd_o by priority DOWN > ROR > ROL > LEFT > RIGHT, set cmd_valid_o=1 (registered) and go to ISSUE. Otherwise stay in ARB.
  - ISSUE: hold cmd_valid_o=1 with cmd_o stable until cmd_valid_o && cmd_ready_i. On that transfer cycle, clear the issued pending bit, drive cmd_valid_o=0 at the next edge and go to ARB.
- Spacing: at least one cycle with cmd_valid_o=0 separates consecutive commands, giving a maximum of one command per 2 cycles.
- Set-vs-clear: if a new edge or tick for the same request arrives in the transfer cycle, set wins and the bit remains pending.
- Latency: a button rising at edge N gives pending at edge N+1 and cmd_valid_o=1 after edge N+2, provided the FSM is in ARB and this is the highest-priority request.
- busy_o (combinational) = |pending || cmd_valid_o.
- en falling during ISSUE: the command is abandoned, cmd_valid_o=0 at the next edge, and nothing is re-issued.
- Reset mid-operation: immediate clear, no handshake completion.

Test Plan:
- Reset then en=1, no buttons, soft_drop=0, DROP_PERIOD=100, cmd_ready_i=1 -> first cmd_valid_o with cmd_o=4 at cycle ~101. Repeats every 100 cycles. missed_tick_o=0.
- Pulse rr high for 1 cycle, cmd_ready_i=1 -> cmd_o=2 valid exactly 2 cycles after the rise, for 1 cycle. Holding rr for 50 cycles yields exactly one ROR.
- right and left rise the same cycle -> no command. Separately, left at cycle 5 and rr at cycle 5 -> ROR issued first, then LEFT, with 1 idle cycle between.
- cmd_ready_i=0 for 20 cycles with cmd_valid_o=1 and cmd_o=3 -> cmd_o stable and valid held throughout. Raising ready -> single transfer, then valid=0.
- cmd_ready_i=0 across two gravity periods (FAST_PERIOD=10, soft_drop=1) -> missed_tick_o=1, still set after ready returns. Only one DOWN is issued for the coalesced ticks.
- Assert rst, or drop en, while in ISSUE with pending bits -> cmd_valid_o=0 and busy_o=0 (immediately for rst, next edge for en). No stale command after re-enable.

Source files
------------

// File: rtl/tetris_move_scheduler.sv
// Tetris move scheduler: edge-detects buttons, generates gravity ticks,
// arbitrates pending moves and issues them over a valid/ready handshake.
module tetris_move_scheduler #(
  parameter int DROP_PERIOD = 100,
  parameter int FAST_PERIOD = 10,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       right,
  input  logic       left,
  input  logic       rr,
  input  logic       rl,
  input  logic       soft_drop,
  input  logic       cmd_ready_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_o,
  output logic       busy_o,
  output logic       missed_tick_o
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ISSUE
  } state_t;

  localparam logic [2:0] M_RIGHT = 3'd0;
  localparam logic [2:0] M_LEFT  = 3'd1;
  localparam logic [2:0] M_ROR   = 3'd2;
  localparam logic [2:0] M_ROL   = 3'd3;
  localparam logic [2:0] M_DOWN  = 3'd4;

  state_t        state;
  logic [3:0]    btn;
  logic [3:0]    prev;
  logic [3:0]    rise;
  logic [4:0]    pend;
  logic [4:0]    set_mask;
  logic [4:0]    clr_mask;
  logic [4:0]    pend_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic          tick;
  logic          xfer;
  logic [2:0]    sel;

  assign btn  = {rl, rr, left, right};
  assign rise = btn & ~prev;

  // >= so a shrinking period (soft drop raised) wraps at once
  assign term = soft_drop ? CW'(FAST_PERIOD - 1)
                          : CW'(DROP_PERIOD - 1);
  assign tick = (cnt >= term);

  // opposing buttons rising together cancel each other
  assign set_mask = {
    tick,
    rise[3] & ~rise[2],
    rise[2] & ~rise[3],
    rise[1] & ~rise[0],
    rise[0] & ~rise[1]
  };

  assign xfer     = (state == ISSUE) && cmd_valid_o && cmd_ready_i;
  assign clr_mask = xfer ? (5'd1 << cmd_o) : 5'd0;
  assign pend_nxt = (pend & ~clr_mask) | set_mask;

  assign busy_o = (|pend) || cmd_valid_o;

  always_comb begin
    sel = M_RIGHT;
    priority case (1'b1)
      pend[4]: sel = M_DOWN;
      pend[2]: sel = M_ROR;
      pend[3]: sel = M_ROL;
      pend[1]: sel = M_LEFT;
      default: sel = M_RIGHT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      prev          <= '0;
      pend          <= '0;
      cnt           <= '0;
      cmd_valid_o   <= 1'b0;
      cmd_o         <= M_RIGHT;
      missed_tick_o <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      prev        <= '0;
      pend        <= '0;
      cnt         <= '0;
      cmd_valid_o <= 1'b0;
    end else begin
      prev <= btn;
      pend <= pend_nxt;
      cnt  <= tick ? '0 : cnt + CW'(1);
      if (tick && pend[4] && !clr_mask[4])
        missed_tick_o <= 1'b1;
      case (state)
        IDLE: state <= ARB;
        ARB: begin
          if (|pend) begin
            cmd_o       <= sel;
            cmd_valid_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            cmd_valid_o <= 1'b0;
            state       <= ARB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Bench for tetris_move_scheduler: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_tetris_move_scheduler;

  localparam int DROP = 100;
  localparam int FAST = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       right = 1'b0;
  logic       left = 1'b0;
  logic       rr = 1'b0;
  logic       rl = 1'b0;
  logic       soft_drop = 1'b0;
  logic       cmd_ready_i = 1'b0;
  logic       cmd_valid_o;
  logic [2:0] cmd_o;
  logic       busy_o;
  logic       missed_tick_o;

  int n_cmp = 0;
  int n_err = 0;

  tetris_move_scheduler #(
    .DROP_PERIOD(DROP),
    .FAST_PERIOD(FAST),
    .CW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .right(right),
    .left(left),
    .rr(rr),
    .rl(rl),
    .soft_drop(soft_drop),
    .cmd_ready_i(cmd_ready_i),
    .cmd_valid_o(cmd_valid_o),
    .cmd_o(cmd_o),
    .busy_o(busy_o),
    .missed_tick_o(missed_tick_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input bit r, input bit l,
                         input bit a, input bit b);
    right = r;
    left  = l;
    rr    = a;
    rl    = b;
  endtask

  // ---- behavioural reference model ----
  bit m_pend[5];
  bit m_prev[4];
  int m_cnt;
  bit m_valid;
  int m_cmd;
  bit m_missed;
  bit m_idle;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_pend[i] = 0;
    for (int i = 0; i < 4; i++) m_prev[i] = 0;
    m_cnt = 0;
    m_valid = 0;
    m_cmd = 0;
    m_missed = 0;
    m_idle = 1;
  endtask

  task automatic model_step(input bit e, input bit b0, input bit b1,
                            input bit b2, input bit b3,
                            input bit sd, input bit rdy);
    bit cur[4];
    bit rise[4];
    bit req[5];
    bit old[5];
    bit xfer;
    bit tick;
    int period;
    int prio[5];
    prio = '{4, 2, 3, 1, 0};
    if (!e) begin
      for (int i = 0; i < 5; i++) m_pend[i] = 0;
      for (int i = 0; i < 4; i++) m_prev[i] = 0;
      m_cnt = 0;
      m_valid = 0;
      m_idle = 1;
      return;
    end
    cur = '{b0, b1, b2, b3};
    xfer = m_valid && rdy;
    period = sd ? FAST : DROP;
    tick = (m_cnt + 1 >= period);
    m_cnt = tick ? 0 : m_cnt + 1;
    for (int i = 0; i < 4; i++) begin
      rise[i] = cur[i] && !m_prev[i];
      m_prev[i] = cur[i];
    end
    req[0] = rise[0] && !rise[1];
    req[1] = rise[1] && !rise[0];
    req[2] = rise[2] && !rise[3];
    req[3] = rise[3] && !rise[2];
    req[4] = tick;
    old = m_pend;
    for (int i = 0; i < 5; i++)
      m_pend[i] = req[i] || (old[i] && !(xfer && m_cmd == i));
    if (tick && old[4] && !(xfer && m_cmd == 4)) m_missed = 1;
    if (m_idle) begin
      m_idle = 0;
    end else if (m_valid) begin
      if (xfer) m_valid = 0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (!m_valid && old[prio[k]]) begin
          m_valid = 1;
          m_cmd = prio[k];
        end
      end
    end
  endtask

  function automatic bit m_busy();
    bit b;
    b = m_valid;
    for (int i = 0; i < 5; i++) b = b | m_pend[i];
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    set_btn(0, 0, 0, 0);
    soft_drop = 1'b0;
    cmd_ready_i = 1'b0;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  // ---- vector table ----
  typedef struct {
    bit e;
    bit r;
    bit l;
    bit a;
    bit b;
    bit rdy;
    bit ev;
    int ec;
    bit eb;
  } vec_t;

  vec_t vt[20];

  initial begin
    int first;
    int gap;
    int bad;
    int nv;
    bit got;

    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1};
    vt[3]  = '{1, 0, 0, 1, 0, 0, 1, 2, 1};
    vt[4]  = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
    vt[5]  = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
    vt[6]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[7]  = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
    vt[8]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[9]  = '{1, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[10] = '{1, 0, 1, 1, 0, 0, 1, 2, 1};
    vt[11] = '{1, 0, 1, 1, 0, 0, 1, 2, 1};
    vt[12] = '{1, 0, 1, 1, 0, 1, 0, 0, 1};
    vt[13] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    vt[14] = '{1, 0, 1, 1, 0, 1, 0, 0, 0};
    vt[15] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vt[16] = '{1, 0, 0, 0, 1, 0, 1, 3, 1};
    vt[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};

    #2;
    chk("reset_valid", int'(cmd_valid_o), 0);
    chk("reset_cmd", int'(cmd_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_missed", int'(missed_tick_o), 0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      en = vt[i].e;
      set_btn(vt[i].r, vt[i].l, vt[i].a, vt[i].b);
      cmd_ready_i = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), int'(cmd_valid_o), int'(vt[i].ev));
      chk($sformatf("vec%0d_busy", i), int'(busy_o), int'(vt[i].eb));
      if (vt[i].ev)
        chk($sformatf("vec%0d_cmd", i), int'(cmd_o), vt[i].ec);
    end
    chk("vec_missed", int'(missed_tick_o), 0);

    // gravity at normal speed
    do_reset();
    en = 1'b1;
    cmd_ready_i = 1'b1;
    first = -1;
    for (int k = 1; k <= 150 && first < 0; k++) begin
      step();
      if (cmd_valid_o) first = k;
    end
    chk("grav_first_cycle", first, 101);
    chk("grav_first_cmd", int'(cmd_o), 4);
    gap = -1;
    step();
    chk("grav_single_cycle", int'(cmd_valid_o), 0);
    for (int k = 2; k <= 150 && gap < 0; k++) begin
      step();
      if (cmd_valid_o) gap = k;
    end
    chk("grav_period", gap, 100);
    step();
    chk("grav_missed", int'(missed_tick_o), 0);

    // coalesced ticks while stalled at fast speed
    soft_drop = 1'b1;
    cmd_ready_i = 1'b0;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      step();
      got = cmd_valid_o;
    end
    chk("fast_valid_seen", int'(got), 1);
    chk("fast_cmd", int'(cmd_o), 4);
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (!cmd_valid_o || cmd_o != 3'd4) bad++;
    end
    chk("fast_hold_bad", bad, 0);
    chk("fast_missed", int'(missed_tick_o), 1);
    cmd_ready_i = 1'b1;
    soft_drop = 1'b0;
    step();
    chk("fast_xfer_valid", int'(cmd_valid_o), 0);
    chk("fast_xfer_busy", int'(busy_o), 0);
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (cmd_valid_o) nv++;
    end
    chk("fast_single_down", nv, 0);
    chk("fast_missed_sticky", int'(missed_tick_o), 1);

    // stalled ROL held stable
    do_reset();
    en = 1'b1;
    step();
    rl = 1'b1;
    step();
    step();
    chk("hold_valid", int'(cmd_valid_o), 1);
    chk("hold_cmd", int'(cmd_o), 3);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!cmd_valid_o || cmd_o != 3'd3) bad++;
    end
    chk("hold_stable_bad", bad, 0);
    cmd_ready_i = 1'b1;
    step();
    chk("hold_after_valid", int'(cmd_valid_o), 0);
    chk("hold_after_busy", int'(busy_o), 0);
    step();
    chk("hold_no_repeat", int'(cmd_valid_o), 0);

    // reset while issuing
    do_reset();
    en = 1'b1;
    step();
    set_btn(0, 1, 1, 0);
    step();
    step();
    chk("rst_pre_valid", int'(cmd_valid_o), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", int'(cmd_valid_o), 0);
    chk("rst_async_busy", int'(busy_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_btn(0, 0, 0, 0);
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (cmd_valid_o || busy_o) nv++;
    end
    chk("rst_no_stale", nv, 0);

    // enable dropped while issuing
    set_btn(0, 1, 1, 0);
    step();
    step();
    chk("en_pre_valid", int'(cmd_valid_o), 1);
    en = 1'b0;
    set_btn(0, 0, 0, 0);
    step();
    chk("en_drop_valid", int'(cmd_valid_o), 0);
    chk("en_drop_busy", int'(busy_o), 0);
    en = 1'b1;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (cmd_valid_o || busy_o) nv++;
    end
    chk("en_no_stale", nv, 0);

    // randomized against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        en = ($urandom_range(99) != 0);
        if ($urandom_range(7) == 0) right = ~right;
        if ($urandom_range(7) == 0) left = ~left;
        if ($urandom_range(7) == 0) rr = ~rr;
        if ($urandom_range(7) == 0) rl = ~rl;
        if ($urandom_range(49) == 0) soft_drop = ~soft_drop;
        cmd_ready_i = ($urandom_range(3) == 0);
        step();
        model_step(en, right, left, rr, rl, soft_drop, cmd_ready_i);
        chk($sformatf("rnd%0d_valid", c), int'(cmd_valid_o), int'(m_valid));
        chk($sformatf("rnd%0d_cmd", c), int'(cmd_o), m_cmd);
        chk($sformatf("rnd%0d_busy", c), int'(busy_o), int'(m_busy()));
        chk($sformatf("rnd%0d_missed", c), int'(missed_tick_o),
            int'(m_missed));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
